l1state_ctl: RTL
================

Name: l1state_ctl

Overview:
- Controller and arbiter for the single-ported L1 MESI state array (l1state).
- Shares the one set-address port among three requesters:
  - load/store lookup pipe (read-only)
  - fill engine (write-only)
  - snoop/invalidate engine (atomic read-modify-write)
- Drives the array's mm1 read/write controls and routes the mm2 read data back to the requester that issued the read.

Parameters:
- STARVE_LIMIT, 4: consecutive denied lookup cycles after which lookup outranks fill.
- SNP_ID_W, 4: width of the snoop transaction ID echoed in the snoop response.
- LK_ID_W, 4: width of the lookup tag echoed in the lookup response.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- lk_req_mm1  in  1  lookup read request.
- lk_set_mm1  in  t_l1_set_addr  lookup set.
- lk_id_mm1  in  LK_ID_W  lookup tag.
- lk_gnt_mm1  out  1  lookup granted this cycle.
- lk_rsp_valid_mm2  out  1  lookup state valid.
- lk_rsp_id_mm2  out  LK_ID_W  echoed tag.
- lk_rsp_ways_mm2  out  t_mesi[L1_NUM_WAYS]  per-way state.
- fl_req_mm1  in  1  fill write request.
- fl_set_mm1  in  t_l1_set_addr  fill set.
- fl_way_mm1  in  t_l1_way  fill way.
- fl_state_mm1  in  t_mesi  fill state.
- fl_gnt_mm1  out  1  fill granted (write performed this cycle).
- snp_req_mm1  in  1  snoop RMW request.
- snp_set_mm1  in  t_l1_set_addr  snoop set.
- snp_way_mm1  in  t_l1_way  snoop way.
- snp_kind_mm1  in  t_snp_kind  SNP_INV or SNP_SHR.
- snp_id_mm1  in  SNP_ID_W  snoop ID.
- snp_gnt_mm1  out  1  snoop read phase issued.
- snp_rsp_valid  out  1  snoop complete.
- snp_rsp_id  out  SNP_ID_W  echoed snoop ID.
- snp_rsp_old_state  out  t_mesi  state before modification.
- state_rd_en_mm1  out  1  array read enable.
- state_wr_en_mm1  out  1  array write enable.
- set_addr_mm1  out  t_l1_set_addr  array set address.
- state_wr_state_mm1  out  t_mesi  array write data.
- state_wr_way_mm1  out  t_l1_way  array write way.
- state_rd_ways_mm2  in  t_mesi[L1_NUM_WAYS]  array read data, one cycle after rd_en.

Behaviour:
- Request/grant handshake:
  - Grant is combinational from the request in the same cycle.
  - A requester holds its request and payload stable until granted.
  - At most one grant per cycle; read and write are never both asserted in one cycle.
- Priority, highest first:
  1. Snoop write phase (SNP_WR state; not a grantable request).
  2. Lookup, when starve_cnt == STARVE_LIMIT.
  3. Fill.
  4. Snoop read phase.
  5. Lookup.
- Starvation counter (starve_cnt):
  - Increments while lk_req_mm1 is asserted and not granted.
  - Saturates at STARVE_LIMIT.
  - Clears on lk_gnt_mm1, or when lk_req_mm1 is low.
- Lookup grant:
  - Drives rd_en=1 and set=lk_set.
  - Next cycle: lk_rsp_valid_mm2=1, lk_rsp_id_mm2 = registered lk_id, lk_rsp_ways_mm2 = state_rd_ways_mm2.
- Fill grant: drives wr_en=1 with fill set/way/state; no response.
- Snoop FSM:
  - SNP_IDLE -> SNP_WR on snp_gnt.
    - The grant drives rd_en=1 and set=snp_set.
    - Registers set, way, kind and id.
  - SNP_WR -> SNP_IDLE unconditionally.
    - Drives wr_en=1, set=registered set, way=registered way.
    - old = state_rd_ways_mm2[way]; write data = next(old, kind).
    - Same cycle: snp_rsp_valid=1, snp_rsp_id, snp_rsp_old_state=old.
  - snp_gnt is never asserted in SNP_WR, so back-to-back snoops issue at most every 2 cycles.
  - Writing immediately after the read makes the RMW atomic; no other access can intervene.
- Next-state function:
  - SNP_INV: any state -> I.
  - SNP_SHR: M->S, E->S, S->S, I->I.
  - The write is performed even when the state is unchanged.
- Array outputs when idle:
  - rd_en=0 and wr_en=0.
  - set, way and write data are don't-care; drive 0.
- Reset (asserted low, asynchronous):
  - FSM -> SNP_IDLE; starve_cnt=0.
  - All gnt/valid outputs and rd_en/wr_en = 0; rsp data = 0.
  - Reset asserted during SNP_WR drops the write and the response; the snoop requester re-issues after reset.

Decomposition:
- mem_common package: t_mesi, t_snp_kind, and the function mesi_snp_next(t_mesi, t_snp_kind).
- mem_defs package: L1_NUM_SETS, L1_NUM_WAYS, t_l1_set_addr, t_l1_way.
- No sub-module. Arbitration, starvation counter and snoop FSM live flat in l1state_ctl; l1state is instantiated alongside it by the parent.

Test Plan:
- Lookup alone, set 5, id 3, array holds {M,I,S,E} -> lk_gnt same cycle; next cycle lk_rsp_valid, id 3, ways {M,I,S,E}.
- Fill and lookup both requesting for 6 cycles -> fill granted cycles 0-3; lookup granted cycle 4 once starve_cnt=4; counter then clears.
- Snoop SHR, set 2 way 1, state E -> cycle0 rd_en; cycle1 wr_en with S, snp_rsp_old_state=E; fill requesting in cycle1 is not granted until cycle2.
- Snoop INV on M, then immediate second snoop -> second snp_gnt no earlier than cycle2; both old states reported; way ends in I.
- Fill set 7 way 0 = E, then lookup set 7 -> lookup returns way0=E.
- Reset asserted in SNP_WR -> wr_en and snp_rsp_valid 0; FSM IDLE after release; array way unchanged.

Source files
------------

// File: rtl/mem_common_pkg.sv
// -----------------------------------------------------------------------------
// mem_common: coherence types shared by the L1 and its controllers.
//   t_mesi        - MESI line state as stored in the state array
//   t_snp_kind    - kind of external snoop (invalidate / downgrade to shared)
//   mesi_snp_next - state a line takes after being hit by a snoop
// -----------------------------------------------------------------------------
package mem_common;

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } t_mesi;

    typedef enum logic {
        SNP_INV = 1'b0,
        SNP_SHR = 1'b1
    } t_snp_kind;

    // Invalidate always ends in I; a share-snoop demotes any valid line to S
    // and leaves an invalid line invalid.
    function automatic t_mesi mesi_snp_next(input t_mesi cur, input t_snp_kind kind);
        t_mesi nxt;
        if (kind == SNP_INV) begin
            nxt = MESI_I;
        end else if (cur == MESI_I) begin
            nxt = MESI_I;
        end else begin
            nxt = MESI_S;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/mem_defs_pkg.sv
// -----------------------------------------------------------------------------
// mem_defs: L1 geometry and the address/way types derived from it.
//   L1_NUM_SETS, L1_NUM_WAYS - array dimensions
//   t_l1_set_addr            - set index
//   t_l1_way                 - way index
// -----------------------------------------------------------------------------
package mem_defs;

    localparam int L1_NUM_SETS = 64;
    localparam int L1_NUM_WAYS = 4;

    typedef logic [$clog2(L1_NUM_SETS)-1:0] t_l1_set_addr;
    typedef logic [$clog2(L1_NUM_WAYS)-1:0] t_l1_way;

endpackage

// File: rtl/l1state_ctl.sv
// -----------------------------------------------------------------------------
// l1state_ctl: arbiter/controller for the single-ported L1 MESI state array.
//
// Three requesters share the one set-address port:
//   lk_*   lookup pipe, read only; per-way state returned one cycle later
//   fl_*   fill engine, write only; no response
//   snp_*  snoop engine, atomic read-modify-write of one way
// Array side:
//   state_rd_en_mm1 / state_wr_en_mm1 / set_addr_mm1 / state_wr_way_mm1 /
//   state_wr_state_mm1 drive the array; state_rd_ways_mm2 is its read data,
//   valid the cycle after a read.
// Grants are combinational from the requests; at most one access per cycle.
// Priority: snoop write phase > starved lookup > fill > snoop read > lookup.
// reset is asynchronous, active low.
// -----------------------------------------------------------------------------
module l1state_ctl
    import mem_common::*;
    import mem_defs::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int SNP_ID_W     = 4,
    parameter int LK_ID_W      = 4
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic                          lk_req_mm1,
    input  t_l1_set_addr                  lk_set_mm1,
    input  logic [LK_ID_W-1:0]            lk_id_mm1,
    output logic                          lk_gnt_mm1,
    output logic                          lk_rsp_valid_mm2,
    output logic [LK_ID_W-1:0]            lk_rsp_id_mm2,
    output t_mesi [L1_NUM_WAYS-1:0]       lk_rsp_ways_mm2,

    input  logic                          fl_req_mm1,
    input  t_l1_set_addr                  fl_set_mm1,
    input  t_l1_way                       fl_way_mm1,
    input  t_mesi                         fl_state_mm1,
    output logic                          fl_gnt_mm1,

    input  logic                          snp_req_mm1,
    input  t_l1_set_addr                  snp_set_mm1,
    input  t_l1_way                       snp_way_mm1,
    input  t_snp_kind                     snp_kind_mm1,
    input  logic [SNP_ID_W-1:0]           snp_id_mm1,
    output logic                          snp_gnt_mm1,
    output logic                          snp_rsp_valid,
    output logic [SNP_ID_W-1:0]           snp_rsp_id,
    output t_mesi                         snp_rsp_old_state,

    output logic                          state_rd_en_mm1,
    output logic                          state_wr_en_mm1,
    output t_l1_set_addr                  set_addr_mm1,
    output t_mesi                         state_wr_state_mm1,
    output t_l1_way                       state_wr_way_mm1,
    input  t_mesi [L1_NUM_WAYS-1:0]       state_rd_ways_mm2
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    typedef enum logic {
        SNP_IDLE = 1'b0,
        SNP_WR   = 1'b1
    } t_snp_state;

    t_snp_state            snp_state_q, snp_state_d;
    logic [STARVE_W-1:0]   starve_cnt_q, starve_cnt_d;
    t_l1_set_addr          snp_set_q, snp_set_d;
    t_l1_way               snp_way_q, snp_way_d;
    t_snp_kind             snp_kind_q, snp_kind_d;
    logic [SNP_ID_W-1:0]   snp_id_q, snp_id_d;
    logic                  lk_rsp_valid_q, lk_rsp_valid_d;
    logic [LK_ID_W-1:0]    lk_rsp_id_q, lk_rsp_id_d;

    logic                  lk_urgent;
    t_mesi                 snp_old;

    // The snoop read was issued last cycle, so the array output now holds the
    // set being modified.
    assign snp_old   = state_rd_ways_mm2[snp_way_q];
    assign lk_urgent = lk_req_mm1 && (starve_cnt_q == STARVE_MAX);

    always_comb begin
        lk_gnt_mm1         = 1'b0;
        fl_gnt_mm1         = 1'b0;
        snp_gnt_mm1        = 1'b0;
        snp_rsp_valid      = 1'b0;
        snp_rsp_id         = '0;
        snp_rsp_old_state  = MESI_I;
        state_rd_en_mm1    = 1'b0;
        state_wr_en_mm1    = 1'b0;
        set_addr_mm1       = '0;
        state_wr_way_mm1   = '0;
        state_wr_state_mm1 = MESI_I;
        snp_state_d        = snp_state_q;
        snp_set_d          = snp_set_q;
        snp_way_d          = snp_way_q;
        snp_kind_d         = snp_kind_q;
        snp_id_d           = snp_id_q;

        if (snp_state_q == SNP_WR) begin
            // Write phase of the RMW: issued back-to-back with the read so no
            // other access can slip in between.
            state_wr_en_mm1    = 1'b1;
            set_addr_mm1       = snp_set_q;
            state_wr_way_mm1   = snp_way_q;
            state_wr_state_mm1 = mesi_snp_next(snp_old, snp_kind_q);
            snp_rsp_valid      = 1'b1;
            snp_rsp_id         = snp_id_q;
            snp_rsp_old_state  = snp_old;
            snp_state_d        = SNP_IDLE;
        end else if (lk_urgent) begin
            lk_gnt_mm1      = 1'b1;
            state_rd_en_mm1 = 1'b1;
            set_addr_mm1    = lk_set_mm1;
        end else if (fl_req_mm1) begin
            fl_gnt_mm1         = 1'b1;
            state_wr_en_mm1    = 1'b1;
            set_addr_mm1       = fl_set_mm1;
            state_wr_way_mm1   = fl_way_mm1;
            state_wr_state_mm1 = fl_state_mm1;
        end else if (snp_req_mm1) begin
            snp_gnt_mm1     = 1'b1;
            state_rd_en_mm1 = 1'b1;
            set_addr_mm1    = snp_set_mm1;
            snp_set_d       = snp_set_mm1;
            snp_way_d       = snp_way_mm1;
            snp_kind_d      = snp_kind_mm1;
            snp_id_d        = snp_id_mm1;
            snp_state_d     = SNP_WR;
        end else if (lk_req_mm1) begin
            lk_gnt_mm1      = 1'b1;
            state_rd_en_mm1 = 1'b1;
            set_addr_mm1    = lk_set_mm1;
        end
    end

    always_comb begin
        lk_rsp_valid_d = lk_gnt_mm1;
        lk_rsp_id_d    = lk_gnt_mm1 ? lk_id_mm1 : lk_rsp_id_q;

        // Counts denied lookup cycles; any grant or a dropped request restarts it.
        if (!lk_req_mm1 || lk_gnt_mm1) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q == STARVE_MAX) begin
            starve_cnt_d = starve_cnt_q;
        end else begin
            starve_cnt_d = starve_cnt_q + STARVE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            snp_state_q    <= SNP_IDLE;
            starve_cnt_q   <= '0;
            snp_set_q      <= '0;
            snp_way_q      <= '0;
            snp_kind_q     <= SNP_INV;
            snp_id_q       <= '0;
            lk_rsp_valid_q <= 1'b0;
            lk_rsp_id_q    <= '0;
        end else begin
            snp_state_q    <= snp_state_d;
            starve_cnt_q   <= starve_cnt_d;
            snp_set_q      <= snp_set_d;
            snp_way_q      <= snp_way_d;
            snp_kind_q     <= snp_kind_d;
            snp_id_q       <= snp_id_d;
            lk_rsp_valid_q <= lk_rsp_valid_d;
            lk_rsp_id_q    <= lk_rsp_id_d;
        end
    end

    assign lk_rsp_valid_mm2 = lk_rsp_valid_q;
    assign lk_rsp_id_mm2    = lk_rsp_id_q;
    // Read data is only meaningful with valid; hold it at I otherwise so the
    // response bus is quiet out of reset.
    assign lk_rsp_ways_mm2  = lk_rsp_valid_q ? state_rd_ways_mm2 : {L1_NUM_WAYS{MESI_I}};

endmodule
